// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the 2:1 AXI-Lite arbiter.
//   state_e : arbiter FSM states
//   op_e    : transaction kind remembered for the write/read tie-break
//   RESP_*  : single-bit response encodings used on the b/r channels
package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4
    } state_e;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } op_e;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin grant decision.
//   req_i       : request bit per requester
//   rr_ptr_i    : preferred requester this round
//   grant_idx_o : preferred requester if it is requesting, otherwise the other one
// The result is only meaningful when at least one request bit is set.
module rr_arbiter_2 (
    input  logic [1:0] req_i,
    input  logic       rr_ptr_i,
    output logic       grant_idx_o
);

    assign grant_idx_o = req_i[rr_ptr_i] ? rr_ptr_i : ~rr_ptr_i;

endmodule

// File: rtl/axi_lite_arbiter_2to1.sv
// Shares one AXI-Lite master port (m1) between two requesters (s0, s1).
// Round-robin between requesters, one transaction outstanding on m1 at a time,
// response routed back to the granted requester only.
//   axi_aclk / axi_areset : clock, synchronous active-high reset
//   s0_axi_* / s1_axi_*   : requester-side AW, W, B, AR, R channels
//   m1_axi_*              : shared master-side AW, W, B, AR, R channels
module axi_lite_arbiter_2to1
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    axi_aclk,
    input  logic                    axi_areset,

    input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
    input  logic                    s0_axi_awvalid,
    output logic                    s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
    input  logic                    s0_axi_wvalid,
    output logic                    s0_axi_wready,
    output logic                    s0_axi_bresp,
    output logic                    s0_axi_bvalid,
    input  logic                    s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
    input  logic                    s0_axi_arvalid,
    output logic                    s0_axi_arready,
    output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
    output logic                    s0_axi_rresp,
    output logic                    s0_axi_rvalid,
    input  logic                    s0_axi_rready,

    input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
    input  logic                    s1_axi_awvalid,
    output logic                    s1_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
    input  logic                    s1_axi_wvalid,
    output logic                    s1_axi_wready,
    output logic                    s1_axi_bresp,
    output logic                    s1_axi_bvalid,
    input  logic                    s1_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
    input  logic                    s1_axi_arvalid,
    output logic                    s1_axi_arready,
    output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
    output logic                    s1_axi_rresp,
    output logic                    s1_axi_rvalid,
    input  logic                    s1_axi_rready,

    output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
    output logic                    m1_axi_awvalid,
    input  logic                    m1_axi_awready,
    output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
    output logic                    m1_axi_wvalid,
    input  logic                    m1_axi_wready,
    input  logic                    m1_axi_bresp,
    input  logic                    m1_axi_bvalid,
    output logic                    m1_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
    output logic                    m1_axi_arvalid,
    input  logic                    m1_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
    input  logic                    m1_axi_rresp,
    input  logic                    m1_axi_rvalid,
    output logic                    m1_axi_rready
);

    // Requester channels packed by index so the grant can select them directly.
    logic [1:0][ADDR_WIDTH-1:0]   awaddr, araddr;
    logic [1:0][DATA_WIDTH-1:0]   wdata;
    logic [1:0][DATA_WIDTH/8-1:0] wstrb;
    logic [1:0]                   awvalid, wvalid, arvalid, bready, rready;
    logic [1:0]                   wr_req, rd_req, req;

    assign awaddr  = {s1_axi_awaddr,  s0_axi_awaddr};
    assign araddr  = {s1_axi_araddr,  s0_axi_araddr};
    assign wdata   = {s1_axi_wdata,   s0_axi_wdata};
    assign wstrb   = {s1_axi_wstrb,   s0_axi_wstrb};
    assign awvalid = {s1_axi_awvalid, s0_axi_awvalid};
    assign wvalid  = {s1_axi_wvalid,  s0_axi_wvalid};
    assign arvalid = {s1_axi_arvalid, s0_axi_arvalid};
    assign bready  = {s1_axi_bready,  s0_axi_bready};
    assign rready  = {s1_axi_rready,  s0_axi_rready};

    assign wr_req = awvalid & wvalid;
    assign rd_req = arvalid;
    assign req    = wr_req | rd_req;

    state_e state_q, state_d;
    op_e    last_op_q, last_op_d;
    op_e    op_sel;
    logic   grant_q, grant_d;
    logic   rr_ptr_q, rr_ptr_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;
    logic   arb_grant;

    // Response/ready signals for the granted requester before port steering.
    logic                  g_awready, g_wready, g_bvalid, g_bresp;
    logic                  g_arready, g_rvalid, g_rresp;
    logic [DATA_WIDTH-1:0] g_rdata;

    rr_arbiter_2 u_rr_arbiter (
        .req_i       (req),
        .rr_ptr_i    (rr_ptr_q),
        .grant_idx_o (arb_grant)
    );

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            rr_ptr_q  <= 1'b0;
            last_op_q <= READ;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            last_op_q <= last_op_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        last_op_d = last_op_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        op_sel    = WRITE;

        m1_axi_awaddr  = '0;
        m1_axi_awvalid = 1'b0;
        m1_axi_wdata   = '0;
        m1_axi_wstrb   = '0;
        m1_axi_wvalid  = 1'b0;
        m1_axi_bready  = 1'b0;
        m1_axi_araddr  = '0;
        m1_axi_arvalid = 1'b0;
        m1_axi_rready  = 1'b0;

        g_awready = 1'b0;
        g_wready  = 1'b0;
        g_bvalid  = 1'b0;
        g_bresp   = RESP_OKAY;
        g_arready = 1'b0;
        g_rvalid  = 1'b0;
        g_rdata   = '0;
        g_rresp   = RESP_OKAY;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = arb_grant;
                    // A requester offering both kinds alternates relative to the last served op.
                    if (wr_req[arb_grant] && rd_req[arb_grant]) begin
                        op_sel = (last_op_q == READ) ? WRITE : READ;
                    end else begin
                        op_sel = rd_req[arb_grant] ? READ : WRITE;
                    end
                    state_d = (op_sel == WRITE) ? WR_ADDR : RD_ADDR;
                end
            end
            WR_ADDR: begin
                m1_axi_awaddr  = awaddr[grant_q];
                m1_axi_awvalid = awvalid[grant_q] & ~aw_done_q;
                m1_axi_wdata   = wdata[grant_q];
                m1_axi_wstrb   = wstrb[grant_q];
                m1_axi_wvalid  = wvalid[grant_q] & ~w_done_q;
                g_awready      = m1_axi_awready & ~aw_done_q;
                g_wready       = m1_axi_wready & ~w_done_q;
                // AW and W complete independently; the done flags stop re-issuing either.
                aw_done_d = aw_done_q | (m1_axi_awvalid & m1_axi_awready);
                w_done_d  = w_done_q | (m1_axi_wvalid & m1_axi_wready);
                if (aw_done_d && w_done_d) begin
                    state_d   = WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WR_RESP: begin
                g_bvalid      = m1_axi_bvalid;
                g_bresp       = m1_axi_bresp;
                m1_axi_bready = bready[grant_q];
                if (m1_axi_bvalid && bready[grant_q]) begin
                    state_d   = IDLE;
                    rr_ptr_d  = ~grant_q;
                    last_op_d = WRITE;
                end
            end
            RD_ADDR: begin
                m1_axi_araddr  = araddr[grant_q];
                m1_axi_arvalid = arvalid[grant_q];
                g_arready      = m1_axi_arready;
                if (arvalid[grant_q] && m1_axi_arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                g_rvalid      = m1_axi_rvalid;
                g_rdata       = m1_axi_rdata;
                g_rresp       = m1_axi_rresp;
                m1_axi_rready = rready[grant_q];
                if (m1_axi_rvalid && rready[grant_q]) begin
                    state_d   = IDLE;
                    rr_ptr_d  = ~grant_q;
                    last_op_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Steer granted-side signals to one requester; the other sees zeros.
    assign s0_axi_awready = g_awready & ~grant_q;
    assign s0_axi_wready  = g_wready  & ~grant_q;
    assign s0_axi_bvalid  = g_bvalid  & ~grant_q;
    assign s0_axi_bresp   = g_bresp   & ~grant_q;
    assign s0_axi_arready = g_arready & ~grant_q;
    assign s0_axi_rvalid  = g_rvalid  & ~grant_q;
    assign s0_axi_rresp   = g_rresp   & ~grant_q;
    assign s0_axi_rdata   = grant_q ? '0 : g_rdata;

    assign s1_axi_awready = g_awready & grant_q;
    assign s1_axi_wready  = g_wready  & grant_q;
    assign s1_axi_bvalid  = g_bvalid  & grant_q;
    assign s1_axi_bresp   = g_bresp   & grant_q;
    assign s1_axi_arready = g_arready & grant_q;
    assign s1_axi_rvalid  = g_rvalid  & grant_q;
    assign s1_axi_rresp   = g_rresp   & grant_q;
    assign s1_axi_rdata   = grant_q ? g_rdata : '0;

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
module tb_axi_lite_arbiter_2to1;

    typedef struct packed {
        logic        port;
        logic        is_rd;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]  s_awaddr [2];
    logic        s_awvalid[2];
    logic [31:0] s_wdata  [2];
    logic [3:0]  s_wstrb  [2];
    logic        s_wvalid [2];
    logic        s_bready [2];
    logic [7:0]  s_araddr [2];
    logic        s_arvalid[2];
    logic        s_rready [2];
    logic        s_awready[2];
    logic        s_wready [2];
    logic        s_bresp  [2];
    logic        s_bvalid [2];
    logic        s_arready[2];
    logic [31:0] s_rdata  [2];
    logic        s_rresp  [2];
    logic        s_rvalid [2];

    logic [7:0]  m_awaddr, m_araddr;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bresp, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rresp, m_rvalid, m_rready;

    axi_lite_arbiter_2to1 #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .axi_aclk(clk), .axi_areset(rst),
        .s0_axi_awaddr(s_awaddr[0]), .s0_axi_awvalid(s_awvalid[0]), .s0_axi_awready(s_awready[0]),
        .s0_axi_wdata(s_wdata[0]), .s0_axi_wstrb(s_wstrb[0]), .s0_axi_wvalid(s_wvalid[0]),
        .s0_axi_wready(s_wready[0]), .s0_axi_bresp(s_bresp[0]), .s0_axi_bvalid(s_bvalid[0]),
        .s0_axi_bready(s_bready[0]), .s0_axi_araddr(s_araddr[0]), .s0_axi_arvalid(s_arvalid[0]),
        .s0_axi_arready(s_arready[0]), .s0_axi_rdata(s_rdata[0]), .s0_axi_rresp(s_rresp[0]),
        .s0_axi_rvalid(s_rvalid[0]), .s0_axi_rready(s_rready[0]),
        .s1_axi_awaddr(s_awaddr[1]), .s1_axi_awvalid(s_awvalid[1]), .s1_axi_awready(s_awready[1]),
        .s1_axi_wdata(s_wdata[1]), .s1_axi_wstrb(s_wstrb[1]), .s1_axi_wvalid(s_wvalid[1]),
        .s1_axi_wready(s_wready[1]), .s1_axi_bresp(s_bresp[1]), .s1_axi_bvalid(s_bvalid[1]),
        .s1_axi_bready(s_bready[1]), .s1_axi_araddr(s_araddr[1]), .s1_axi_arvalid(s_arvalid[1]),
        .s1_axi_arready(s_arready[1]), .s1_axi_rdata(s_rdata[1]), .s1_axi_rresp(s_rresp[1]),
        .s1_axi_rvalid(s_rvalid[1]), .s1_axi_rready(s_rready[1]),
        .m1_axi_awaddr(m_awaddr), .m1_axi_awvalid(m_awvalid), .m1_axi_awready(m_awready),
        .m1_axi_wdata(m_wdata), .m1_axi_wstrb(m_wstrb), .m1_axi_wvalid(m_wvalid),
        .m1_axi_wready(m_wready), .m1_axi_bresp(m_bresp), .m1_axi_bvalid(m_bvalid),
        .m1_axi_bready(m_bready), .m1_axi_araddr(m_araddr), .m1_axi_arvalid(m_arvalid),
        .m1_axi_arready(m_arready), .m1_axi_rdata(m_rdata), .m1_axi_rresp(m_rresp),
        .m1_axi_rvalid(m_rvalid), .m1_axi_rready(m_rready)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int cyc0 = 0;

    // requester-side intent
    bit          aw_vld[2], w_vld[2], ar_vld[2], wr_pend[2], rd_pend[2];
    logic [7:0]  wa[2], ra[2];
    logic [31:0] wd[2];
    logic [3:0]  ws[2];

    // m1-side responder state
    bit          aw_got, w_got, ar_got, b_vld, r_vld;
    int          b_cnt, r_cnt;
    logic        b_resp_v, r_resp_v;
    logic [31:0] r_data_v;

    // knobs
    bit          fast, hold_resp, use_fix, lat_chk, first_done;
    int          fix_delay;
    logic        fix_resp;
    logic [31:0] fix_rdata;

    // reference model: abstract arbitration state
    bit          mdl_ptr;
    bit          mdl_last_rd;
    txn_t        exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_all();
        for (int p = 0; p < 2; p++) begin
            aw_vld[p] = 0; w_vld[p] = 0; ar_vld[p] = 0; wr_pend[p] = 0; rd_pend[p] = 0;
            s_awaddr[p] = '0; s_awvalid[p] = 0; s_wdata[p] = '0; s_wstrb[p] = '0;
            s_wvalid[p] = 0; s_bready[p] = 0; s_araddr[p] = '0; s_arvalid[p] = 0; s_rready[p] = 0;
        end
        m_awready = 0; m_wready = 0; m_bresp = 0; m_bvalid = 0;
        m_arready = 0; m_rdata = '0; m_rresp = 0; m_rvalid = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_vld = 0; r_vld = 0;
        b_cnt = -1; r_cnt = -1; b_resp_v = 0; r_resp_v = 0; r_data_v = '0;
    endtask

    function automatic int resp_delay();
        if (use_fix) return fix_delay;
        if (fast) return 0;
        return int'($urandom_range(0, 4));
    endfunction

    // Expected service order from the arbitration rules applied to the pending set.
    task automatic load_round();
        bit w[2], r[2];
        bit ptr, last, g, rd;
        txn_t t;
        for (int p = 0; p < 2; p++) begin
            w[p] = wr_pend[p]; r[p] = rd_pend[p];
            aw_vld[p] = wr_pend[p]; w_vld[p] = wr_pend[p]; ar_vld[p] = rd_pend[p];
        end
        ptr = mdl_ptr; last = mdl_last_rd;
        while (w[0] || r[0] || w[1] || r[1]) begin
            g  = (w[ptr] || r[ptr]) ? ptr : !ptr;
            rd = (w[g] && r[g]) ? !last : r[g];
            t.port  = g;
            t.is_rd = rd;
            t.addr  = rd ? ra[g] : wa[g];
            t.data  = rd ? 32'h0 : wd[g];
            t.strb  = ws[g];
            exp_q.push_back(t);
            if (rd) r[g] = 0; else w[g] = 0;
            ptr = !g; last = rd;
        end
        mdl_ptr = ptr; mdl_last_rd = last;
    endtask

    task automatic step();
        bit   m_aw_hs, m_w_hs, m_ar_hs, m_b_hs, m_r_hs, have, done;
        bit   s_b_hs[2], s_r_hs[2];
        txn_t f;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            s_awvalid[p] = aw_vld[p]; s_awaddr[p] = wa[p];
            s_wvalid[p] = w_vld[p]; s_wdata[p] = wd[p]; s_wstrb[p] = ws[p];
            s_arvalid[p] = ar_vld[p]; s_araddr[p] = ra[p];
            s_bready[p] = fast || ($urandom_range(0, 3) != 0);
            s_rready[p] = fast || ($urandom_range(0, 3) != 0);
        end
        m_awready = fast || ($urandom_range(0, 1) != 0);
        m_wready  = fast || ($urandom_range(0, 1) != 0);
        m_arready = fast || ($urandom_range(0, 1) != 0);
        m_bvalid = b_vld; m_bresp = b_resp_v;
        m_rvalid = r_vld; m_rdata = r_data_v; m_rresp = r_resp_v;
        #1;
        cyc++;
        m_aw_hs = m_awvalid && m_awready;
        m_w_hs  = m_wvalid && m_wready;
        m_ar_hs = m_arvalid && m_arready;
        m_b_hs  = m_bvalid && m_bready;
        m_r_hs  = m_rvalid && m_rready;
        have = (exp_q.size() != 0);
        f = have ? exp_q[0] : '0;
        for (int p = 0; p < 2; p++) begin
            s_b_hs[p] = s_bvalid[p] && s_bready[p];
            s_r_hs[p] = s_rvalid[p] && s_rready[p];
            if (!have || p != int'(f.port)) begin
                chk("idle_port_ctl", {s_awready[p], s_wready[p], s_bvalid[p], s_bresp[p],
                                      s_arready[p], s_rvalid[p], s_rresp[p]}, 0);
                chk("idle_port_rdata", s_rdata[p], 0);
            end
        end
        if (have) begin
            chk("req_pass", {s_awvalid[f.port] && s_awready[f.port], s_wvalid[f.port] && s_wready[f.port],
                             s_arvalid[f.port] && s_arready[f.port]}, {m_aw_hs, m_w_hs, m_ar_hs});
        end
        if (aw_got) chk("aw_quiet", m_awvalid, 0);
        if (w_got)  chk("w_quiet", m_wvalid, 0);
        if (ar_got) chk("ar_quiet", m_arvalid, 0);
        if (m_aw_hs) begin
            chk("aw_is_write", have && !f.is_rd, 1);
            chk("aw_addr", m_awaddr, f.addr);
        end
        if (m_w_hs) begin
            chk("w_is_write", have && !f.is_rd, 1);
            chk("w_data", m_wdata, f.data);
            chk("w_strb", m_wstrb, f.strb);
        end
        if (m_ar_hs) begin
            chk("ar_is_read", have && f.is_rd, 1);
            chk("ar_addr", m_araddr, f.addr);
        end
        if (m_b_hs || s_b_hs[0] || s_b_hs[1]) begin
            chk("b_route", {s_b_hs[1], s_b_hs[0]}, (have && m_b_hs) ? (f.port ? 2'b10 : 2'b01) : 2'b00);
            chk("b_is_write", have && !f.is_rd, 1);
            if (have) chk("bresp", s_bresp[f.port], b_resp_v);
        end
        if (m_r_hs || s_r_hs[0] || s_r_hs[1]) begin
            chk("r_route", {s_r_hs[1], s_r_hs[0]}, (have && m_r_hs) ? (f.port ? 2'b10 : 2'b01) : 2'b00);
            chk("r_is_read", have && f.is_rd, 1);
            if (have) begin
                chk("rdata", s_rdata[f.port], r_data_v);
                chk("rresp", s_rresp[f.port], r_resp_v);
            end
        end
        done = have && (f.is_rd ? s_r_hs[f.port] : s_b_hs[f.port]);
        if (done) begin
            if (lat_chk && !first_done) chk("min_latency", cyc - cyc0 + 1, 3);
            first_done = 1;
            void'(exp_q.pop_front());
        end
        for (int p = 0; p < 2; p++) begin
            if (s_awvalid[p] && s_awready[p]) aw_vld[p] = 0;
            if (s_wvalid[p] && s_wready[p])   w_vld[p] = 0;
            if (s_arvalid[p] && s_arready[p]) ar_vld[p] = 0;
            if (s_b_hs[p]) wr_pend[p] = 0;
            if (s_r_hs[p]) rd_pend[p] = 0;
        end
        if (m_aw_hs) aw_got = 1;
        if (m_w_hs)  w_got = 1;
        if (m_ar_hs) ar_got = 1;
        if (m_b_hs) begin b_vld = 0; aw_got = 0; w_got = 0; b_cnt = -1; end
        if (m_r_hs) begin r_vld = 0; ar_got = 0; r_cnt = -1; end
        if (aw_got && w_got && !b_vld && !hold_resp) begin
            if (b_cnt < 0) b_cnt = resp_delay();
            if (b_cnt == 0) begin
                b_vld = 1;
                b_resp_v = use_fix ? fix_resp : 1'($urandom_range(0, 1));
            end else b_cnt--;
        end
        if (ar_got && !r_vld && !hold_resp) begin
            if (r_cnt < 0) r_cnt = resp_delay();
            if (r_cnt == 0) begin
                r_vld = 1;
                r_data_v = use_fix ? fix_rdata : $urandom;
                r_resp_v = use_fix ? fix_resp : 1'($urandom_range(0, 1));
            end else r_cnt--;
        end
    endtask

    task automatic run_round(input bit f_fast, input bit do_lat);
        fast = f_fast; lat_chk = do_lat; first_done = 0;
        load_round();
        cyc0 = cyc + 1;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) step();
        chk("round_done", exp_q.size(), 0);
        exp_q.delete();
        use_fix = 0;
    endtask

    task automatic rand_port(input int p);
        wa[p] = {p[0], 1'b0, 6'($urandom)};
        ra[p] = {p[0], 1'b1, 6'($urandom)};
        wd[p] = $urandom;
        ws[p] = 4'($urandom);
    endtask

    initial begin
        rst = 1; fast = 0; hold_resp = 0; use_fix = 0; lat_chk = 0; first_done = 0;
        fix_delay = 0; fix_resp = 0; fix_rdata = '0;
        mdl_ptr = 0; mdl_last_rd = 1;
        clear_all();
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        chk("reset_s_ctl", {s_awready[0], s_wready[0], s_bvalid[0], s_arready[0], s_rvalid[0],
                            s_awready[1], s_wready[1], s_bvalid[1], s_arready[1], s_rvalid[1]}, 0);
        chk("reset_m_ctl", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);

        // single s0 write at full rate
        wr_pend[0] = 1; wa[0] = 8'h04; wd[0] = 32'h17; ws[0] = 4'hF;
        use_fix = 1; fix_delay = 0; fix_resp = 0;
        run_round(1, 1);

        // s1 read with a slow response and error status
        rd_pend[1] = 1; ra[1] = 8'h0C; ws[1] = 4'h0;
        use_fix = 1; fix_delay = 4; fix_rdata = 32'h25; fix_resp = 1;
        run_round(1, 0);

        // s0 offers a write and a read together after a read
        wr_pend[0] = 1; wa[0] = 8'h00; wd[0] = 32'h1E; ws[0] = 4'hF;
        rd_pend[0] = 1; ra[0] = 8'h08;
        run_round(0, 0);

        // both requesters keep writing
        for (int k = 0; k < 3; k++) begin
            rand_port(0); rand_port(1);
            wr_pend[0] = 1; wr_pend[1] = 1;
            run_round(0, 0);
        end

        for (int k = 0; k < 80; k++) begin
            for (int p = 0; p < 2; p++) begin
                rand_port(p);
                wr_pend[p] = ($urandom_range(0, 1) != 0);
                rd_pend[p] = ($urandom_range(0, 1) != 0);
            end
            run_round($urandom_range(0, 4) == 0, 0);
        end

        // leave the pointer favouring s1, then abort an s1 read with reset
        rand_port(0); wr_pend[0] = 1;
        run_round(0, 0);
        rand_port(1); rd_pend[1] = 1;
        hold_resp = 1; fast = 1;
        load_round();
        for (int i = 0; i < 20 && !ar_got; i++) step();
        chk("rd_data_reached", ar_got, 1);
        @(negedge clk);
        rst = 1;
        clear_all();
        @(negedge clk);
        rst = 0;
        m_rvalid = 1; m_rdata = 32'hDEAD_BEEF; m_rresp = 1;
        #1;
        chk("abort_s_ctl", {s_awready[0], s_wready[0], s_bvalid[0], s_arready[0], s_rvalid[0],
                            s_awready[1], s_wready[1], s_bvalid[1], s_arready[1], s_rvalid[1]}, 0);
        chk("abort_s1_rdata", s_rdata[1], 0);
        chk("abort_m_ctl", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
        @(negedge clk);
        clear_all();
        exp_q.delete();
        hold_resp = 0;
        mdl_ptr = 0; mdl_last_rd = 1;
        rand_port(0); rand_port(1);
        wr_pend[0] = 1; wr_pend[1] = 1;
        run_round(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
